// File: rtl/systolic_fir_coe_ctrl.sv
// Coefficient-reload controller for the 8-tap symmetric systolic FIR.
// Streams a half-set of coefficients into a shadow bank, swaps it in at an input gap and masks stale outputs.
module systolic_fir_coe_ctrl #(
   parameter int HTAP    = 4,
   parameter int COE_W   = 16,
   parameter int FLUSH_N = 8,
   // h(0)=7, h(1)=14, h(2)=-138, h(3)=129
   parameter logic [HTAP*COE_W-1:0] INIT_COE = 64'h0081_FF76_000E_0007
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [COE_W-1:0]        cfg_data,
   input  logic                    cfg_last,
   input  logic                    xin_valid,
   input  logic                    fir_yvld,
   output logic [HTAP*COE_W-1:0]   coe,
   output logic                    yvld,
   output logic                    swap_done,
   output logic                    err_len,
   output logic                    busy
);

   localparam int KW = (HTAP > 1) ? $clog2(HTAP) : 1;
   localparam int FW = (FLUSH_N > 0) ? $clog2(FLUSH_N + 1) : 1;
   localparam logic [KW-1:0] K_LAST     = KW'(HTAP - 1);
   localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_N);

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, ARMED, FLUSH} state_t;

   state_t           state, state_next;
   logic [KW-1:0]    k, k_next;
   logic [FW-1:0]    cnt, cnt_next;
   logic [COE_W-1:0] shadow [HTAP];
   logic             xfer;
   logic             shadow_we;
   logic             do_swap;
   logic             err_next;

   assign cfg_ready = (state == IDLE) || (state == LOAD) || (state == DRAIN);
   assign xfer      = cfg_valid && cfg_ready;
   assign busy      = (state == ARMED) || (state == FLUSH);
   assign yvld      = fir_yvld && (state != FLUSH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         k     <= k_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      k_next     = k;
      cnt_next   = cnt;
      shadow_we  = 1'b0;
      do_swap    = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (xfer) begin
               shadow_we = 1'b1;
               if (k == K_LAST) begin
                  k_next = '0;
                  if (cfg_last) begin
                     state_next = ARMED;
                  end else begin
                     err_next   = 1'b1;
                     state_next = DRAIN;
                  end
               end else if (cfg_last) begin
                  err_next   = 1'b1;
                  k_next     = '0;
                  state_next = IDLE;
               end else begin
                  k_next     = k + KW'(1);
                  state_next = LOAD;
               end
            end
         end
         DRAIN: begin
            if (xfer && cfg_last) state_next = IDLE;
         end
         ARMED: begin
            if (!xin_valid) begin
               do_swap = 1'b1;
               if (FLUSH_N > 0) begin
                  state_next = FLUSH;
                  cnt_next   = FLUSH_INIT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         FLUSH: begin
            if (fir_yvld) begin
               cnt_next = cnt - FW'(1);
               if (cnt <= FW'(1)) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shadow/active banks and the registered event pulses; partial shadow writes from bad sets are harmless
   // because every accepted set rewrites all HTAP entries before it can be swapped in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coe       <= INIT_COE;
         swap_done <= 1'b0;
         err_len   <= 1'b0;
         for (int i = 0; i < HTAP; i++) shadow[i] <= INIT_COE[i*COE_W +: COE_W];
      end else begin
         swap_done <= do_swap;
         err_len   <= err_next;
         if (shadow_we) shadow[k] <= cfg_data;
         if (do_swap) begin
            for (int i = 0; i < HTAP; i++) coe[i*COE_W +: COE_W] <= shadow[i];
         end
      end
   end

endmodule

// File: doc/systolic_fir_coe_ctrl.md
# systolic_fir_coe_ctrl

Coefficient-reload controller for the 8-tap symmetric systolic FIR: accepts a new half-set of coefficients over a valid/ready stream into a shadow bank and swaps it into the active bank at a gap in the input sample stream. After a swap it masks the FIR output-valid while the pipeline still holds mixed old/new products. It sits between the configuration master and the FIR datapath and drives the FIR's coefficient bus directly.

## Interface
- HTAP, 4, number of unique coefficients (TAP/2)
- COE_W, 16, coefficient width, signed
- FLUSH_N, 8, number of FIR output beats masked after each swap; 0 disables masking
- INIT_COE, {7, 14, -138, 129}, reset contents of the active bank, h(0) first

- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cfg_valid  in  1  coefficient word valid
- cfg_ready  out  1  controller accepts a word
- cfg_data  in  COE_W  coefficient word, signed; words arrive h(0) first
- cfg_last  in  1  marks the final word of a set
- xin_valid  in  1  FIR input sample strobe; monitored only, for gap detection
- fir_yvld  in  1  raw FIR output valid
- coe  out  HTAP*COE_W  active bank; h(k) on bits [k*COE_W +: COE_W]
- yvld  out  1  masked output valid = fir_yvld AND (state != FLUSH)
- swap_done  out  1  one-cycle pulse, high in the cycle coe takes new values
- err_len  out  1  one-cycle pulse on a malformed set
- busy  out  1  high in ARMED or FLUSH

## Operation
- States: IDLE, LOAD, DRAIN, ARMED, FLUSH. Word index k counts from 0 to HTAP-1.
- cfg_ready = 1 in IDLE, LOAD, DRAIN; 0 in ARMED, FLUSH. A word transfers when cfg_valid & cfg_ready.
- IDLE/LOAD: each transferred word is written to shadow[k], then k increments. IDLE moves to LOAD on the first word.
- Transfer with k == HTAP-1 and cfg_last=1: go to ARMED, k cleared.
- Transfer with k < HTAP-1 and cfg_last=1: err_len pulse, shadow discarded, go to IDLE, k cleared.
- Transfer with k == HTAP-1 and cfg_last=0: err_len pulse. Go to DRAIN.
- DRAIN: words are accepted and dropped until a word with cfg_last=1 transfers, then go to IDLE. No second err_len pulse is issued.
- ARMED: on the first cycle with xin_valid == 0, the active bank is loaded from shadow and swap_done pulses.
  - If FLUSH_N > 0: go to FLUSH with the flush counter = FLUSH_N.
  - Otherwise: go to IDLE.
  - ARMED waits indefinitely while xin_valid stays 1.
- FLUSH: yvld is forced to 0. Each fir_yvld beat decrements the counter; the beat that brings it to 0 is still masked, then go to IDLE.
- coe changes only on a swap or on reset. Malformed sets never alter coe.
- Reset, including mid-operation, aborts any load/arm/flush in progress:
  - state = IDLE, k = 0, flush counter = 0;
  - coe = INIT_COE, shadow = INIT_COE;
  - swap_done = 0, err_len = 0, busy = 0.

## Timing
- After reset: cfg_ready = 1, yvld follows fir_yvld, coe = 0x0081_FF76_000E_0007 for the defaults.
- Word transfer in cycle t updates shadow at the edge ending t. A last word in cycle t gives state ARMED in t+1.
- The swap decision uses xin_valid in the same cycle (cycle s). coe, swap_done and the FLUSH state are all registered at the edge ending s and visible in s+1.
  - Result: a sample presented in s+1 already uses the new set.
- err_len is registered: it is high in the cycle after the offending transfer.
- yvld is combinational from fir_yvld and the state register, with zero latency.
- busy = 1 from the first ARMED cycle through the last FLUSH cycle.
- A cfg_valid held through ARMED/FLUSH is not lost. It is accepted in the first IDLE cycle, i.e. the cycle after the final masked beat.

## Test plan
- Reset release:
  - coe = 0x0081_FF76_000E_0007, cfg_ready = 1, busy = 0.
  - fir_yvld pulses pass straight to yvld.
- Load 1, 2, 3, 4 (last on 4) while xin_valid is held 1 for 10 cycles, then dropped:
  - busy = 1 with coe unchanged for those 10 cycles.
  - In the cycle after xin_valid drops: swap_done = 1 and coe = 0x0004_0003_0002_0001.
  - The next 8 fir_yvld beats are masked; the 9th appears on yvld.
- Short set 5, 6, 7 with last on 7:
  - err_len pulse one cycle after the 7 transfer, state IDLE, coe unchanged.
- Long set of 6 words, last on word 6:
  - err_len pulse after word 4 only; words 5–6 are accepted and dropped.
  - A following valid set 1, 2, 3, 4 swaps correctly.
- cfg_valid held high during ARMED and FLUSH:
  - cfg_ready = 0 throughout, with no transfer.
  - The first transfer occurs the cycle after the 8th masked beat, and its data lands in shadow[0].
- Assert rst during FLUSH after 3 masked beats:
  - coe = INIT_COE immediately, yvld unmasked, busy = 0.
  - No swap_done until a fresh set is loaded.
